// File: rtl/read_pkg.sv
// Shared widths, FSM state encoding and step count for the 16x8 dividend reconstructor.
package read_pkg;

    localparam int DIVIDEND_W   = 16;
    localparam int DIVISOR_W    = 8;
    localparam int QUOT_W       = 8;
    localparam int REMULT_STEPS = 8;
    localparam int CNT_W        = $clog2(REMULT_STEPS);

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/read_remult_16x8_step.sv
// One radix-2 shift-add step: conditional add of the shifted multiplicand, then shift both operands.
import read_pkg::*;

module remult_step (
    input  logic [DIVIDEND_W-1:0] acc,
    input  logic [DIVIDEND_W-1:0] mcand,
    input  logic [QUOT_W-1:0]     mplr,
    output logic [DIVIDEND_W-1:0] acc_next,
    output logic [DIVIDEND_W-1:0] mcand_next,
    output logic [QUOT_W-1:0]     mplr_next
);

    // Maximum q*y+r is 0xFF00, so the 16-bit sum never needs a carry-out.
    assign acc_next   = mplr[0] ? (acc + mcand) : acc;
    assign mcand_next = mcand << 1;
    assign mplr_next  = mplr >> 1;

endmodule

// File: rtl/read_remult_16x8.sv
// Sequential dividend reconstructor p = q*y + r using an 8-step shift-add loop.
// Optional dividend check against x is enabled by defining READ_REMULT_CHECK_EN.
import read_pkg::*;

module read_remult_16x8 (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [QUOT_W-1:0]     q,
    input  logic [DIVISOR_W-1:0]  y,
    input  logic [DIVISOR_W-1:0]  r,
`ifdef READ_REMULT_CHECK_EN
    input  logic [DIVIDEND_W-1:0] x,
    output logic                  mismatch,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] p
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(REMULT_STEPS - 1);

    state_t                  state;
    logic [DIVIDEND_W-1:0]   acc;
    logic [DIVIDEND_W-1:0]   mcand;
    logic [QUOT_W-1:0]       mplr;
    logic [CNT_W-1:0]        cnt;
    logic [DIVIDEND_W-1:0]   acc_next;
    logic [DIVIDEND_W-1:0]   mcand_next;
    logic [QUOT_W-1:0]       mplr_next;
    logic                    accept;
`ifdef READ_REMULT_CHECK_EN
    logic [DIVIDEND_W-1:0]   x_lat;
`endif

    remult_step u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplr       (mplr),
        .acc_next   (acc_next),
        .mcand_next (mcand_next),
        .mplr_next  (mplr_next)
    );

    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);
    // DONE accepts a new request directly so back-to-back ops have no idle gap.
    assign accept = start && (state != ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
            p     <= '0;
`ifdef READ_REMULT_CHECK_EN
            x_lat    <= '0;
            mismatch <= 1'b0;
`endif
        end else if (accept) begin
            acc   <= {{(DIVIDEND_W-DIVISOR_W){1'b0}}, r};
            mcand <= {{(DIVIDEND_W-DIVISOR_W){1'b0}}, y};
            mplr  <= q;
            cnt   <= '0;
            state <= ST_RUN;
`ifdef READ_REMULT_CHECK_EN
            x_lat <= x;
`endif
        end else begin
            case (state)
                ST_RUN: begin
                    acc   <= acc_next;
                    mcand <= mcand_next;
                    mplr  <= mplr_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        p     <= acc_next;
                        state <= ST_DONE;
`ifdef READ_REMULT_CHECK_EN
                        mismatch <= (acc_next != x_lat);
`endif
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_remult_16x8.sv
// Directed bench for read_remult_16x8: latency, arithmetic corners, back-to-back ops, reset abort.
module tb_read_remult_16x8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  q;
    logic [7:0]  y;
    logic [7:0]  r;
    logic [15:0] x;
    logic        busy;
    logic        done;
    logic [15:0] p;
`ifdef READ_REMULT_CHECK_EN
    logic        mismatch;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    read_remult_16x8 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .q        (q),
        .y        (y),
        .r        (r),
`ifdef READ_REMULT_CHECK_EN
        .x        (x),
        .mismatch (mismatch),
`endif
        .busy     (busy),
        .done     (done),
        .p        (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one op, scramble operands while busy, and check latency, busy length and result.
    task automatic do_op(input string tag, input logic [7:0] qi, input logic [7:0] yi,
                         input logic [7:0] ri, input logic [15:0] xi,
                         input logic [15:0] exp_p, input logic exp_mm);
        int edges;
        int busy_cycles;
        q = qi; y = yi; r = ri; x = xi; start = 1'b1;
        tick();
        start = 1'b0;
        q = 8'hA5; y = 8'h5A; r = 8'hC3; x = 16'hDEAD;
        edges = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && edges < 20) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
            edges++;
        end
        chk({tag, "_edges"}, edges, 8);
        chk({tag, "_busy_cycles"}, busy_cycles, 8);
        chk({tag, "_p"}, {16'h0, p}, {16'h0, exp_p});
        chk({tag, "_busy_at_done"}, {31'h0, busy}, 0);
`ifdef READ_REMULT_CHECK_EN
        chk({tag, "_mismatch"}, {31'h0, mismatch}, {31'h0, exp_mm});
`endif
        tick();
        chk({tag, "_done_pulse"}, {31'h0, done}, 0);
        chk({tag, "_p_hold"}, {16'h0, p}, {16'h0, exp_p});
    endtask

    initial begin
        int seen_done;
        rst = 1'b1; start = 1'b0; q = '0; y = '0; r = '0; x = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", {31'h0, busy}, 0);
        chk("reset_done", {31'h0, done}, 0);
        chk("reset_p", {16'h0, p}, 0);
`ifdef READ_REMULT_CHECK_EN
        chk("reset_mismatch", {31'h0, mismatch}, 0);
`endif
        tick();

        do_op("op_2a_07_03", 8'h2A, 8'h07, 8'h03, 16'h0129, 16'h0129, 1'b0);
        do_op("op_ff_ff_ff", 8'hFF, 8'hFF, 8'hFF, 16'hFF00, 16'hFF00, 1'b0);
        do_op("op_y_zero", 8'h55, 8'h00, 8'h11, 16'h0011, 16'h0011, 1'b0);
        do_op("op_q_zero", 8'h00, 8'h9C, 8'h42, 16'h0042, 16'h0042, 1'b0);

        // start held high: second op accepted in the DONE cycle, operand changes while busy ignored
        q = 8'h10; y = 8'h10; r = 8'h01; x = 16'h0101; start = 1'b1;
        tick();
        q = 8'h02; y = 8'h03; r = 8'h04; x = 16'h000A;
        for (int i = 0; i < 7; i++) tick();
        chk("b2b_a_busy_last", {31'h0, busy}, 1);
        chk("b2b_a_no_early_done", {31'h0, done}, 0);
        tick();
        chk("b2b_a_done", {31'h0, done}, 1);
        chk("b2b_a_p", {16'h0, p}, 32'h0101);
        tick();
        start = 1'b0;
        q = 8'hEE; y = 8'hEE; r = 8'hEE; x = 16'h1234;
        chk("b2b_no_gap_busy", {31'h0, busy}, 1);
        chk("b2b_single_done", {31'h0, done}, 0);
        chk("b2b_p_hold", {16'h0, p}, 32'h0101);
        for (int i = 0; i < 7; i++) tick();
        chk("b2b_b_no_early_done", {31'h0, done}, 0);
        tick();
        chk("b2b_b_done", {31'h0, done}, 1);
        chk("b2b_b_p", {16'h0, p}, 32'h000A);
        tick();
        chk("b2b_idle", {31'h0, busy | done}, 0);

        // reset in the 4th RUN cycle aborts the op without a done
        q = 8'h2A; y = 8'h07; r = 8'h03; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("abort_busy_before", {31'h0, busy}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'h0, busy}, 0);
        chk("abort_done", {31'h0, done}, 0);
        chk("abort_p", {16'h0, p}, 0);
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen_done++;
            tick();
        end
        chk("abort_no_done", seen_done, 0);
        do_op("op_after_abort", 8'h03, 8'h05, 8'h01, 16'h0010, 16'h0010, 1'b0);

`ifdef READ_REMULT_CHECK_EN
        do_op("chk_match", 8'h2A, 8'h07, 8'h03, 16'h0129, 16'h0129, 1'b0);
        do_op("chk_miss", 8'h2A, 8'h07, 8'h03, 16'h012A, 16'h0129, 1'b1);
        q = 8'h2A; y = 8'h07; r = 8'h03; x = 16'h0129; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("chk_miss_held", {31'h0, mismatch}, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("chk_clear_done", {31'h0, done}, 1);
        chk("chk_clear_mismatch", {31'h0, mismatch}, 0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
